// File: rtl/seed_search_sequencer.sv
// Walks a shared search engine through consecutive 128-bit seeds until the masked output matches.
// Optional per-candidate watchdog is compiled in with `define WATCHDOG_EN.
module seed_search_sequencer #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [127:0]     base_seed,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      l_cfg,
  input  logic [127:0]     target,
  input  logic [127:0]     mask,
  output logic [127:0]     eng_s,
  output logic [31:0]      eng_l,
  output logic             eng_rst,
  input  logic             eng_finish,
  input  logic [127:0]     eng_outs,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [127:0]     found_seed,
  output logic [127:0]     found_s,
  output logic [CNT_W-1:0] tried,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [127:0]     seed_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      l_reg;
  logic [127:0]     eng_s_reg;
  logic [31:0]      eng_l_reg;
  logic             fin_reg;
  logic [127:0]     outs_cap_reg;
  logic             found_reg;
  logic [127:0]     found_seed_reg;
  logic [127:0]     found_s_reg;
  logic [CNT_W-1:0] tried_reg;

  logic             run_go;
  logic             kill;
  logic             fin_edge;
  logic             wd_expired;
  logic [3:0]       word_hit;
  logic             is_match;
  logic [CNT_W-1:0] tried_inc;
  logic             is_last;

  assign run_go    = (state_reg == S_IDLE) && start && !abort;
  assign kill      = (state_reg != S_IDLE) && abort;
  assign fin_edge  = eng_finish && !fin_reg;
  assign tried_inc = tried_reg + CNT_W'(1);
  assign is_last   = (tried_inc == count_reg);

  // Masked compare split per 32-bit word of the captured result.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word_cmp
      assign word_hit[gi] =
        (((outs_cap_reg[gi*32 +: 32] ^ target[gi*32 +: 32]) & mask[gi*32 +: 32]) == 32'd0);
    end
  endgenerate
  assign is_match = &word_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (run_go) state_next = (count == '0) ? S_FIN : S_LOAD;
      S_LOAD:  state_next = S_KICK;
      S_KICK:  state_next = S_WAIT;
      S_WAIT: begin
        if (fin_edge)        state_next = S_CHECK;
        else if (wd_expired) state_next = S_FIN;
      end
      S_CHECK: state_next = (is_match || is_last) ? S_FIN : S_LOAD;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (kill) state_next = S_IDLE;
  end

  always_comb begin
    busy    = (state_reg == S_LOAD) || (state_reg == S_KICK) ||
              (state_reg == S_WAIT) || (state_reg == S_CHECK);
    done    = (state_reg == S_FIN) && !abort;
    eng_rst = (state_reg == S_KICK) && !abort;
  end

  // The finish history is re-armed with the live level in KICK, so a level left
  // high by the previous candidate must fall and rise again before it counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_reg       <= '0;
      count_reg      <= '0;
      l_reg          <= '0;
      eng_s_reg      <= '0;
      eng_l_reg      <= '0;
      fin_reg        <= 1'b0;
      outs_cap_reg   <= '0;
      found_reg      <= 1'b0;
      found_seed_reg <= '0;
      found_s_reg    <= '0;
      tried_reg      <= '0;
    end else if (run_go) begin
      seed_reg  <= base_seed;
      count_reg <= count;
      l_reg     <= l_cfg;
      found_reg <= 1'b0;
      tried_reg <= '0;
    end else if (!kill) begin
      case (state_reg)
        S_LOAD: begin
          eng_s_reg <= seed_reg;
          eng_l_reg <= l_reg;
        end
        S_KICK: fin_reg <= eng_finish;
        S_WAIT: begin
          fin_reg <= eng_finish;
          if (fin_edge) outs_cap_reg <= eng_outs;
        end
        S_CHECK: begin
          tried_reg <= tried_inc;
          if (is_match) begin
            found_reg      <= 1'b1;
            found_seed_reg <= seed_reg;
            found_s_reg    <= outs_cap_reg;
          end else if (!is_last) begin
            seed_reg <= seed_reg + 128'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WATCHDOG_EN
  // Expiry is decided in the WAIT cycle that makes FIN land TIMEOUT_CYC cycles after KICK.
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

  logic [WD_W-1:0] wd_reg;
  logic            timeout_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (run_go) timeout_reg <= 1'b0;
      if (state_reg == S_KICK)      wd_reg <= '0;
      else if (state_reg == S_WAIT) wd_reg <= wd_reg + WD_W'(1);
      if (wd_expired && !kill) timeout_reg <= 1'b1;
    end
  end

  assign wd_expired = (state_reg == S_WAIT) && !fin_edge && (wd_reg == WD_LAST);
  assign timeout    = timeout_reg;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign eng_s      = eng_s_reg;
  assign eng_l      = eng_l_reg;
  assign found      = found_reg;
  assign found_seed = found_seed_reg;
  assign found_s    = found_s_reg;
  assign tried      = tried_reg;

endmodule

// File: tb/tb_seed_search_sequencer.sv
// Directed bench for seed_search_sequencer with a delay-programmable engine model and
// scoreboard queues for engine kicks and run-end results.
module tb_seed_search_sequencer;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, abort;
  logic [127:0]     base_seed, target, mask;
  logic [CNT_W-1:0] count;
  logic [31:0]      l_cfg;
  logic [127:0]     eng_s, found_seed, found_s;
  logic [31:0]      eng_l;
  logic             eng_rst, busy, done, found, timeout;
  logic [CNT_W-1:0] tried;
  logic             eng_fin_m = 1'b0;
  logic [127:0]     eng_outs_m = '0;

  always #5 clk = ~clk;

  seed_search_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_seed(base_seed), .count(count), .l_cfg(l_cfg),
    .target(target), .mask(mask),
    .eng_s(eng_s), .eng_l(eng_l), .eng_rst(eng_rst),
    .eng_finish(eng_fin_m), .eng_outs(eng_outs_m),
    .busy(busy), .done(done), .found(found),
    .found_seed(found_seed), .found_s(found_s),
    .tried(tried), .timeout(timeout)
  );

  // Engine model: finish rises eng_dly cycles after a restart with result eng_s+eng_off;
  // eng_dly==0 means it never finishes.
  int           eng_dly = 3;
  logic [127:0] eng_off = '0;
  int           eng_cnt = 0;
  bit           eng_run = 1'b0;
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_fin_m <= 1'b0;
      eng_cnt   <= eng_dly;
      eng_run   <= (eng_dly > 0);
    end else if (eng_run) begin
      if (eng_cnt <= 1) begin
        eng_fin_m  <= 1'b1;
        eng_outs_m <= eng_s + eng_off;
        eng_run    <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [127:0] s;
    logic [31:0]  l;
  } kick_exp_t;
  typedef struct {
    logic         fnd;
    logic [127:0] fseed;
    logic [127:0] fs;
    int           ntried;
    logic         tmo;
  } done_exp_t;

  kick_exp_t sq[$];
  done_exp_t dq[$];

  int errors = 0;
  int checks = 0;
  int rst_cnt = 0, done_cnt = 0, cyc = 0, rst_cyc = 0, done_cyc = 0;
  logic prev_rst = 1'b0, prev_done = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (eng_rst) begin
        kick_exp_t ke;
        rst_cnt++;
        rst_cyc = cyc;
        chk("eng_rst_width", 128'(prev_rst), 128'd0);
        chk("kick_expected", 128'(sq.size() != 0), 128'd1);
        if (sq.size() != 0) begin
          ke = sq.pop_front();
          $display("kick: eng_s=%0h eng_l=%0h", eng_s, eng_l);
          chk("eng_s", eng_s, ke.s);
          chk("eng_l", 128'(eng_l), 128'(ke.l));
        end
      end
      if (done) begin
        done_exp_t de;
        done_cnt++;
        done_cyc = cyc;
        chk("done_width", 128'(prev_done), 128'd0);
        chk("done_expected", 128'(dq.size() != 0), 128'd1);
        if (dq.size() != 0) begin
          de = dq.pop_front();
          $display("done: found=%0b seed=%0h tried=%0d timeout=%0b", found, found_seed, tried, timeout);
          chk("found", 128'(found), 128'(de.fnd));
          chk("tried", 128'(tried), 128'(de.ntried));
          chk("timeout", 128'(timeout), 128'(de.tmo));
          if (de.fnd) begin
            chk("found_seed", found_seed, de.fseed);
            chk("found_s", found_s, de.fs);
          end
        end
      end
      prev_rst  = eng_rst;
      prev_done = done;
    end
  end

  // Builds expectations from the reference behaviour, launches a run and waits for its end.
  task automatic do_run(input logic [127:0] base, input int cnt, input logic [127:0] tgt,
                        input logic [127:0] msk, input logic [31:0] l, input bit poke);
    done_exp_t    de;
    kick_exp_t    ke;
    logic [127:0] s, o;
    int           d0, r0, nk, bound;
    bit           ok;
    de.fnd = 1'b0; de.fseed = '0; de.fs = '0; de.ntried = cnt; de.tmo = 1'b0;
    nk = 0;
    for (int i = 0; i < cnt; i++) begin
      s = base + 128'(i);
      ke.s = s; ke.l = l;
      sq.push_back(ke);
      nk++;
      o = s + eng_off;
      if (((o ^ tgt) & msk) == '0) begin
        de.fnd = 1'b1; de.fseed = s; de.fs = o; de.ntried = i + 1;
        break;
      end
    end
    dq.push_back(de);
    d0 = done_cnt; r0 = rst_cnt;
    base_seed = base; count = CNT_W'(cnt); target = tgt; mask = msk; l_cfg = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      base_seed = 128'hDEAD_BEEF; count = CNT_W'(1); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; base_seed = base; count = CNT_W'(cnt);
    end
    bound = (cnt + 1) * (eng_dly + 10) + 40;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (done_cnt != d0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    chk("run_completes", 128'(ok), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 128'(done_cnt - d0), 128'd1);
    chk("kick_count", 128'(rst_cnt - r0), 128'(nk));
    chk("kick_queue_empty", 128'(sq.size()), 128'd0);
    chk("found_sticky", 128'(found), 128'(de.fnd));
    chk("busy_after_run", 128'(busy), 128'd0);
  endtask

  initial begin
    int r0, d0, busy_n;
    bit ok;
    kick_exp_t ke;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_seed = '0; count = '0; l_cfg = '0; target = '0; mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_eng_s", eng_s, 128'd0);
    chk("rst_eng_l", 128'(eng_l), 128'd0);
    chk("rst_eng_rst", 128'(eng_rst), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_found", 128'(found), 128'd0);
    chk("rst_found_seed", found_seed, 128'd0);
    chk("rst_found_s", found_s, 128'd0);
    chk("rst_tried", 128'(tried), 128'd0);
    chk("rst_timeout", 128'(timeout), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Mask 0 matches the first candidate; slow engine.
    eng_dly = 120; eng_off = 128'd7;
    do_run(128'd2, 10, 128'd0, 128'd0, 32'hA5A5_0001, 1'b0);

    // Engine returns seed+5, target 9: third candidate (seed 4) matches.
    eng_dly = 3; eng_off = 128'd5;
    do_run(128'd2, 10, 128'd9, {128{1'b1}}, 32'h0000_0102, 1'b0);

    // No match over four candidates; a start while busy must be ignored.
    do_run(128'd2, 4, 128'd0, {128{1'b1}}, 32'h0000_0203, 1'b1);

    // Carry from word0 into word1, then all-ones wrapping to zero.
    do_run({96'd0, 32'hFFFF_FFFF}, 2, 128'd0, {128{1'b1}}, 32'h0000_0304, 1'b0);
    do_run({128{1'b1}}, 2, 128'd1, {128{1'b1}}, 32'h0000_0405, 1'b0);

    // count == 0: immediate done, nothing tried.
    do_run(128'd50, 0, 128'd0, 128'd0, 32'h0000_0506, 1'b0);

    // Abort during WAIT of the third candidate.
    eng_dly = 20;
    for (int i = 0; i < 3; i++) begin
      ke.s = 128'd2 + 128'(i); ke.l = 32'h0000_0607;
      sq.push_back(ke);
    end
    r0 = rst_cnt; d0 = done_cnt;
    base_seed = 128'd2; count = CNT_W'(10); target = 128'd0; mask = {128{1'b1}}; l_cfg = 32'h0000_0607;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (rst_cnt - r0 == 3) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    chk("abort_third_kick", 128'(ok), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_tried", 128'(tried), 128'd2);
    chk("abort_found", 128'(found), 128'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
    chk("abort_kicks", 128'(rst_cnt - r0), 128'd3);
    chk("abort_queue_empty", 128'(sq.size()), 128'd0);

    // A fresh run after the abort behaves normally.
    eng_dly = 3;
    do_run(128'd2, 10, 128'd9, {128{1'b1}}, 32'h0000_0708, 1'b0);

    // start and abort together in IDLE: run must not begin.
    r0 = rst_cnt;
    base_seed = 128'd2; count = CNT_W'(3); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 128'(busy), 128'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("start_abort_kicks", 128'(rst_cnt - r0), 128'd0);

    // Engine that never finishes.
    eng_dly = 0;
    ke.s = 128'd7; ke.l = 32'h0000_0809;
    sq.push_back(ke);
    r0 = rst_cnt; d0 = done_cnt;
    base_seed = 128'd7; count = CNT_W'(5); l_cfg = 32'h0000_0809;
`ifdef WATCHDOG_EN
    begin
      done_exp_t de;
      de.fnd = 1'b0; de.fseed = '0; de.fs = '0; de.ntried = 0; de.tmo = 1'b1;
      dq.push_back(de);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt != d0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    chk("wd_done_seen", 128'(ok), 128'd1);
    chk("wd_latency", 128'(done_cyc - rst_cyc), 128'd16);
    chk("wd_timeout_sticky", 128'(timeout), 128'd1);
    chk("wd_tried", 128'(tried), 128'd0);
`else
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    chk("hang_busy_held", 128'(busy_n), 128'd1000);
    chk("hang_no_done", 128'(done_cnt - d0), 128'd0);
    chk("hang_timeout", 128'(timeout), 128'd0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("hang_abort_busy", 128'(busy), 128'd0);
`endif
    chk("final_kick_queue", 128'(sq.size()), 128'd0);
    chk("final_done_queue", 128'(dq.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
